// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial (slice-serial) adder controller.
//   add_state_e : controller FSM states.
//   DEF_WIDTH   : default operand/result width.
//   DEF_SLICE   : default width of the shared adder slice.
//   cnt_width() : slice counter width, max(1, clog2(nslice)).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 2;

  function automatic int cnt_width(input int nslice);
    int w;
    w = $clog2(nslice);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_add_slice.sv
// add_slice: combinational SLICE-bit unsigned adder shared by every step of
// the serial add.
//   a, b : slice operands
//   cin  : slice carry-in
//   sum  : slice sum, modulo 2^SLICE
//   cout : carry out of the slice MSB
module add_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: computes A + B + Carry_i over WIDTH bits by time-sharing a
// single SLICE-bit adder, LSB slice first, one slice per clock. The slice
// carry is chained through a register between steps.
//
// Optional build macro SERIAL_ADD_SUB_EN adds Sub_i: when set at accept the
// controller computes A - B (B inverted, carry-in forced to 1) and Carry_o=1
// then means "no borrow".
//
// Ports:
//   Clk_i, Rst_ni     : clock, synchronous active-low reset
//   Valid_i / Ready_o : operand handshake (Ready_o high only in IDLE)
//   A_i, B_i, Carry_i : operands and carry-in, captured at accept
//   Sub_i             : subtract select (only with SERIAL_ADD_SUB_EN)
//   Valid_o / Ready_i : result handshake (Valid_o high only in DONE)
//   Sum_o, Carry_o    : result, held after the handshake until the next op
//   Busy_o            : high while an operation is in RUN or DONE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             Clk_i,
  input  logic             Rst_ni,
  input  logic             Valid_i,
  output logic             Ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Carry_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub_i,
`endif
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic [WIDTH-1:0] Sum_o,
  output logic             Carry_o,
  output logic             Busy_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_width(NSLICE);

  if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_cfg
    $error("serial_add_ctrl: WIDTH must be a non-zero multiple of SLICE");
  end

  add_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cry_q;

  logic             accept;
  logic             last_step;
  logic             sub_sel;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = Sub_i;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is A + ~B + 1; the forced carry-in replaces Carry_i.
  assign b_load   = sub_sel ? ~B_i : B_i;
  assign cin_load = sub_sel ? 1'b1 : Carry_i;

  assign accept    = (state_q == IDLE) && Valid_i;
  assign last_step = (cnt_q == CW'(NSLICE - 1));

  add_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .cin  (cry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New slice enters at the MSB end; after NSLICE steps the first slice has
  // reached bit 0 and the register holds the aligned result.
  if (NSLICE == 1) begin : g_one_slice
    assign sum_shift = slice_sum;
  end else begin : g_multi_slice
    assign sum_shift = {slice_sum, sum_q[WIDTH-1:SLICE]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Valid_i)   state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (Ready_i)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Control and visible result state.
  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        cry_q <= cin_load;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + CW'(1);
        cry_q <= slice_cout;
        sum_q <= sum_shift;
      end
    end
  end

  // Operand shift registers: contents are don't-care outside RUN.
  always_ff @(posedge Clk_i) begin
    if (accept) begin
      a_q <= A_i;
      b_q <= b_load;
    end else if (state_q == RUN) begin
      a_q <= a_q >> SLICE;
      b_q <= b_q >> SLICE;
    end
  end

  assign Ready_o = (state_q == IDLE);
  assign Valid_o = (state_q == DONE);
  assign Busy_o  = (state_q != IDLE);
  assign Sum_o   = sum_q;
  assign Carry_o = cry_q;

endmodule
